// File: rtl/arm_mem_pkg.sv
// Shared memory-stage definitions: FSM state encoding, the default data-memory
// byte-address map, and the byte-address to SRAM-word conversion helper.
// No ports; imported by the SRAM controller, its interface and DataMemory-style users.
package arm_mem_pkg;

  // Access sequencer states: idle, low halfword phase, high halfword phase, done.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  // Byte address that maps to data word 0; shared so every memory user agrees.
  localparam logic [31:0] MEM_BASE_ADDR       = 32'd1024;
  localparam int unsigned SRAM_AW_DEFAULT     = 18;
  localparam int unsigned WAIT_CYCLES_DEFAULT = 2;

  // Word index of a byte address. Addresses below the base wrap modulo 2^32.
  function automatic logic [31:0] byte_to_word(input logic [31:0] addr,
                                               input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Memory-stage request/response plus the off-chip 16-bit SRAM pin group.
// Pipeline side: mem_r_en, mem_w_en, address, wdata -> rdata, ready.
// SRAM side: sram_addr, sram_dq_out, sram_dq_oe, sram_we_n out; sram_dq_in back in.
interface sram_controller_if
  import arm_mem_pkg::*;
#(
  parameter int unsigned SRAM_AW = SRAM_AW_DEFAULT
);
  logic               mem_r_en;
  logic               mem_w_en;
  logic [31:0]        address;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic [15:0]        sram_dq_in;
  logic               sram_dq_oe;
  logic               sram_we_n;

  // The controller.
  modport slave (
    input  mem_r_en, mem_w_en, address, wdata, sram_dq_in,
    output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  // The pipeline together with the SRAM device.
  modport master (
    output mem_r_en, mem_w_en, address, wdata, sram_dq_in,
    input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_controller.sv
// MEM-stage controller: each 32-bit load/store becomes two 16-bit SRAM phases
// (low half, then high half), each held WAIT_CYCLES cycles; ready drops to freeze the pipeline.
// Ports: clk, rst (async active-low), bus (sram_controller_if.slave: pipeline request + SRAM pins).
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = MEM_BASE_ADDR,
  parameter int unsigned SRAM_AW     = SRAM_AW_DEFAULT,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  sram_controller_if.slave bus
);

  localparam int unsigned    WCW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYCLES - 1);

  mem_state_e         state_q, state_d;
  logic [WCW-1:0]     wait_cnt_q, wait_cnt_d;
  logic               is_wr_q, is_wr_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        word;
  logic [SRAM_AW-1:0] addr_lo, addr_hi;
  logic               req;
  logic               phase_end;

  assign req       = bus.mem_r_en | bus.mem_w_en;
  assign phase_end = (wait_cnt_q == WAIT_LAST);

  // Halfword addresses are {word, half}; the cast drops bits above the SRAM width.
  assign word    = byte_to_word(bus.address, BASE_ADDR);
  assign addr_lo = SRAM_AW'({word, 1'b0});
  assign addr_hi = SRAM_AW'({word, 1'b1});

  assign bus.rdata = rdata_q;

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    is_wr_d         = is_wr_q;
    rdata_d         = rdata_q;
    bus.ready       = 1'b0;
    bus.sram_addr   = '0;
    bus.sram_dq_out = '0;
    bus.sram_dq_oe  = 1'b0;
    bus.sram_we_n   = 1'b1;

    case (state_q)
      ST_IDLE: begin
        bus.ready = !req;
        if (req) begin
          state_d    = ST_LO;
          wait_cnt_d = '0;
          // A store wins when both enables are set.
          is_wr_d    = bus.mem_w_en;
        end
      end

      ST_LO: begin
        bus.sram_addr = addr_lo;
        if (is_wr_q) begin
          bus.sram_dq_oe  = 1'b1;
          bus.sram_we_n   = 1'b0;
          bus.sram_dq_out = bus.wdata[15:0];
        end
        wait_cnt_d = wait_cnt_q + WCW'(1);
        if (phase_end) begin
          state_d    = ST_HI;
          wait_cnt_d = '0;
          if (!is_wr_q) rdata_d[15:0] = bus.sram_dq_in;
        end
      end

      ST_HI: begin
        bus.sram_addr = addr_hi;
        if (is_wr_q) begin
          bus.sram_dq_oe  = 1'b1;
          bus.sram_we_n   = 1'b0;
          bus.sram_dq_out = bus.wdata[31:16];
        end
        wait_cnt_d = wait_cnt_q + WCW'(1);
        if (phase_end) begin
          state_d    = ST_DONE;
          wait_cnt_d = '0;
          if (!is_wr_q) rdata_d[31:16] = bus.sram_dq_in;
        end
      end

      ST_DONE: begin
        bus.ready = 1'b1;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      is_wr_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      is_wr_q    <= is_wr_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: behavioural SRAM device, transaction-level reference
// model checked every cycle, directed cases with literal expectations, then random traffic.
module tb_sram_controller;
  import arm_mem_pkg::*;

  localparam int          W    = 2;
  localparam int          AW   = 18;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int          NPRE = 66;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sram_controller_if #(.SRAM_AW(AW)) intf ();

  sram_controller #(.BASE_ADDR(BASE), .SRAM_AW(AW), .WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM device: async read, write on clock while we_n low ----
  logic [15:0]   sram_mem [0:(1<<AW)-1];
  logic          pre_vld = 1'b0;
  logic [AW-1:0] pre_a   = '0;
  logic [15:0]   pre_d   = '0;

  assign intf.sram_dq_in = sram_mem[intf.sram_addr];

  always @(posedge clk) begin
    if (pre_vld) sram_mem[pre_a] <= pre_d;
    else if (!intf.sram_we_n) sram_mem[intf.sram_addr] <= intf.sram_dq_out;
  end

  // ---------------- Reference model -------------------------------------------
  logic [15:0] ref_mem [logic [AW-1:0]];
  bit          busy = 1'b0;
  int          t = 0;
  bit          m_wr = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_d = '0;
  logic [31:0] exp_rdata = '0;

  function automatic logic [AW-1:0] hw_of(input logic [31:0] a, input bit hi);
    logic [31:0] wd;
    wd = (a - BASE) / 32'd4;
    return AW'((wd * 32'd2 + 32'(hi)) % 32'(1 << AW));
  endfunction

  task automatic chk_idle(input logic exp_ready);
    chk("ready", intf.ready, exp_ready);
    chk("we_n_idle", intf.sram_we_n, 1'b1);
    chk("oe_idle", intf.sram_dq_oe, 1'b0);
    chk("addr_idle", intf.sram_addr, '0);
    chk("dq_out_idle", intf.sram_dq_out, '0);
    chk("rdata", intf.rdata, exp_rdata);
  endtask

  task automatic chk_phase(input logic [AW-1:0] a, input logic [15:0] d);
    chk("ready_busy", intf.ready, 1'b0);
    chk("addr", intf.sram_addr, a);
    chk("oe", intf.sram_dq_oe, m_wr);
    chk("we_n", intf.sram_we_n, !m_wr);
    if (m_wr) begin
      chk("dq_out", intf.sram_dq_out, d);
      ref_mem[a] = d;
    end
  endtask

  // Cycle t of an access: 0 = request seen idle, 1..W low half, W+1..2W high half, 2W+1 done.
  always @(negedge clk) begin
    logic rq;
    rq = intf.mem_r_en | intf.mem_w_en;
    if (pre_vld) ref_mem[pre_a] = pre_d;
    if (!rst) begin
      busy      = 1'b0;
      t         = 0;
      exp_rdata = '0;
      chk_idle(!rq);
    end else begin
      if (!busy && rq) begin
        busy = 1'b1;
        t    = 0;
        m_wr = intf.mem_w_en;
        m_a  = intf.address;
        m_d  = intf.wdata;
      end
      if (!busy || t == 0) chk_idle(!rq);
      else if (t <= W) chk_phase(hw_of(m_a, 1'b0), m_d[15:0]);
      else if (t <= 2 * W) chk_phase(hw_of(m_a, 1'b1), m_d[31:16]);
      else begin
        if (!m_wr) exp_rdata = {ref_mem[hw_of(m_a, 1'b1)], ref_mem[hw_of(m_a, 1'b0)]};
        chk_idle(1'b1);
      end
      if (busy) begin
        t++;
        if (t > 2 * W + 1) busy = 1'b0;
      end
    end
  end

  // ---------------- Driver ------------------------------------------------------
  // Called at posedge+1; returns at posedge+1 of the cycle after ready, enables still applied.
  task automatic run_txn(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int low_cnt, output int we_cnt,
                         output logic [AW-1:0] lo_a, output logic [AW-1:0] hi_a);
    intf.mem_w_en = w;
    intf.mem_r_en = r;
    intf.address  = a;
    intf.wdata    = d;
    lat = -1; low_cnt = 0; we_cnt = 0; lo_a = '0; hi_a = '0;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) lo_a = intf.sram_addr;
      if (c == W + 1) hi_a = intf.sram_addr;
      if (!intf.sram_we_n) we_cnt++;
      if (intf.ready) begin
        if (c > 0) lat = c;
      end else begin
        low_cnt++;
      end
    end
    if (lat < 0) chk("txn_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    intf.mem_w_en = 1'b0;
    intf.mem_r_en = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int            lat, lowc, wec;
    logic [AW-1:0] la, ha;

    intf.mem_r_en = 1'b0;
    intf.mem_w_en = 1'b0;
    intf.address  = '0;
    intf.wdata    = '0;

    // Preload halfwords 0..63 and the two at the top of the SRAM, under reset.
    for (int i = 0; i < NPRE; i++) begin
      @(posedge clk); #1;
      pre_vld = 1'b1;
      pre_a   = (i < 64) ? AW'(i) : AW'((1 << AW) - NPRE + i);
      pre_d   = (i == 4) ? 16'h5678 : (i == 5) ? 16'h1234 : 16'($urandom);
    end
    @(posedge clk); #1;
    pre_vld = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    chk("reset_ready", intf.ready, 1'b1);
    chk("reset_rdata", intf.rdata, 32'h0);
    chk("reset_we_n", intf.sram_we_n, 1'b1);
    @(posedge clk); #1;

    // Store 0xDEADBEEF at the base address.
    run_txn(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lat, lowc, wec, la, ha);
    chk("st_latency", lat, 5);
    chk("st_we_low_cycles", wec, 4);
    chk("st_lo_addr", la, 18'h0);
    chk("st_hi_addr", ha, 18'h1);
    idle(1);
    chk("st_mem0", sram_mem[0], 16'hBEEF);
    chk("st_mem1", sram_mem[1], 16'hDEAD);
    chk("model_mem0", ref_mem[0], 16'hBEEF);

    // Load from preloaded halfwords 4/5.
    run_txn(1'b0, 1'b1, 32'd1032, 32'h0, lat, lowc, wec, la, ha);
    chk("ld_latency", lat, 5);
    chk("ld_we_low_cycles", wec, 0);
    idle(1);
    chk("ld_rdata", intf.rdata, 32'h12345678);

    // Both enables: treated as a store, rdata untouched.
    run_txn(1'b1, 1'b1, 32'd1028, 32'hA5A50F0F, lat, lowc, wec, la, ha);
    idle(1);
    chk("both_mem2", sram_mem[2], 16'h0F0F);
    chk("both_mem3", sram_mem[3], 16'hA5A5);
    chk("both_rdata", intf.rdata, 32'h12345678);

    // Back-to-back store then load of the same word.
    run_txn(1'b1, 1'b0, 32'd1036, 32'h00000007, lat, lowc, wec, la, ha);
    chk("b2b_st_low", lowc, 5);
    run_txn(1'b0, 1'b1, 32'd1036, 32'h0, lat, lowc, wec, la, ha);
    chk("b2b_ld_low", lowc, 5);
    chk("b2b_ld_latency", lat, 5);
    idle(1);
    chk("b2b_rdata", intf.rdata, 32'h00000007);

    // Address below the base wraps to the top of the SRAM.
    run_txn(1'b1, 1'b0, 32'd1020, 32'hCAFEF00D, lat, lowc, wec, la, ha);
    chk("wrap_lo_addr", la, 18'h3FFFE);
    chk("wrap_hi_addr", ha, 18'h3FFFF);
    chk("wrap_latency", lat, 5);
    idle(1);

    // Reset in the second low-phase cycle of a store.
    intf.mem_w_en = 1'b1;
    intf.address  = 32'd1040;
    intf.wdata    = 32'h11112222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_we_n", intf.sram_we_n, 1'b1);
    chk("rst_oe", intf.sram_dq_oe, 1'b0);
    chk("rst_rdata", intf.rdata, 32'h0);
    chk("rst_ready_req", intf.ready, 1'b0);
    chk("rst_state", dut.state_q, ST_IDLE);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready_norq", intf.ready, 1'b1);
    @(posedge clk); #1;

    // Random traffic over the preloaded window plus the wrapped word.
    for (int k = 0; k < 60; k++) begin
      int          sel;
      logic [31:0] a;
      sel = int'($urandom_range(0, 99));
      if ($urandom_range(0, 19) == 0) a = BASE - 32'd4 + 32'($urandom_range(0, 3));
      else a = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      run_txn(sel < 55, sel >= 45, a, $urandom, lat, lowc, wec, la, ha);
      chk("rnd_latency", lat, 2 * W + 1);
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    // SRAM contents must match what the model says was written.
    for (int i = 0; i < NPRE; i++) begin
      logic [AW-1:0] h;
      h = (i < 64) ? AW'(i) : AW'((1 << AW) - NPRE + i);
      chk("final_mem", sram_mem[h], ref_mem[h]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
